// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Stall/flush sequencer for the 5-stage RV32 pipeline (load-use,
//               MDU sequencing, data-memory wait states, branch squash).
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MDU_TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        use_rs1_id,
    input  logic        use_rs2_id,
    input  logic [4:0]  rd_ex,
    input  logic        memread_ex,
    input  logic        branch_taken_ex,
    input  logic        mdu_req_ex,
    input  logic        mdu_done,
    output logic        mdu_start,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        stall_idex,
    output logic        stall_exmem,
    output logic        bubble_idex,
    output logic        bubble_exmem,
    output logic        flush_ifid,
    output logic        mdu_timeout_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LDUSE = 2'd1,
        S_MDU   = 2'd2,
        S_DMEM  = 2'd3
    } state_t;

    localparam logic [7:0] c_LDUSE_INIT = 8'(LOAD_USE_BUBBLES - 1);
    localparam logic [7:0] c_MDU_LIMIT  = 8'(MDU_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_err;
    logic        w_err_set;
    logic [31:0] r_stall_cycles;
    logic        w_hazard;

    assign w_hazard = (rd_ex != 5'd0) &&
                      ((use_rs1_id && (rs1_id == rd_ex)) ||
                       (use_rs2_id && (rs2_id == rd_ex)));

    // Outputs are held low while reset is asserted so an aborted MDU op is never relaunched.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_err_set    = 1'b0;
        mdu_start    = 1'b0;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idex   = 1'b0;
        stall_exmem  = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        flush_ifid   = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_RUN: begin
                    if (dmem_req_mem && !dmem_ready) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        stall_idex  = 1'b1;
                        stall_exmem = 1'b1;
                        w_state_nxt = S_DMEM;
                    end else if (mdu_req_ex) begin
                        mdu_start    = 1'b1;
                        stall_pc     = 1'b1;
                        stall_ifid   = 1'b1;
                        stall_idex   = 1'b1;
                        bubble_exmem = 1'b1;
                        w_cnt_nxt    = 8'd1;
                        w_state_nxt  = S_MDU;
                    end else if (branch_taken_ex) begin
                        flush_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end else if (memread_ex && w_hazard) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            w_cnt_nxt   = c_LDUSE_INIT;
                            w_state_nxt = S_LDUSE;
                        end
                    end
                end
                S_LDUSE: begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    w_cnt_nxt   = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_MDU: begin
                    // Done or timeout both release every hold so EX/MEM captures this cycle.
                    if (mdu_done) begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = S_RUN;
                    end else if (r_cnt == c_MDU_LIMIT) begin
                        w_err_set   = 1'b1;
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = S_RUN;
                    end else begin
                        stall_pc     = 1'b1;
                        stall_ifid   = 1'b1;
                        stall_idex   = 1'b1;
                        bubble_exmem = 1'b1;
                        w_cnt_nxt    = r_cnt + 8'd1;
                    end
                end
                S_DMEM: begin
                    if (dmem_ready) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        stall_idex  = 1'b1;
                        stall_exmem = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_RUN;
            r_cnt          <= 8'd0;
            r_err          <= 1'b0;
            r_stall_cycles <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (stall_pc && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign mdu_timeout_err = r_err;
    assign stall_cycles    = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_ctrl
// Description : Directed self-checking bench for pipeline_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    // Output vector order: {stall_pc, stall_ifid, stall_idex, stall_exmem,
    //                       bubble_idex, bubble_exmem, flush_ifid, mdu_start}
    localparam logic [7:0] c_NONE       = 8'b0000_0000;
    localparam logic [7:0] c_LDUSE      = 8'b1100_1000;
    localparam logic [7:0] c_BRANCH     = 8'b0000_1010;
    localparam logic [7:0] c_MDU_LAUNCH = 8'b1110_0101;
    localparam logic [7:0] c_MDU_HOLD   = 8'b1110_0100;
    localparam logic [7:0] c_DMEM       = 8'b1111_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic       use_rs1_id = 0, use_rs2_id = 0, memread_ex = 0, branch_taken_ex = 0;
    logic       mdu_req_ex = 0, mdu_done = 0, dmem_req_mem = 0, dmem_ready = 0;

    logic        a_start, a_spc, a_sifid, a_sidex, a_sexmem, a_bidex, a_bexmem, a_flush, a_err;
    logic [31:0] a_sc;
    logic        b_start, b_spc, b_sifid, b_sidex, b_sexmem, b_bidex, b_bexmem, b_flush, b_err;
    logic [31:0] b_sc;

    wire [7:0] outs_a = {a_spc, a_sifid, a_sidex, a_sexmem, a_bidex, a_bexmem, a_flush, a_start};
    wire [7:0] outs_b = {b_spc, b_sifid, b_sidex, b_sexmem, b_bidex, b_bexmem, b_flush, b_start};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.LOAD_USE_BUBBLES(2), .MDU_TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
        .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
        .mdu_req_ex(mdu_req_ex), .mdu_done(mdu_done), .mdu_start(a_start),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .stall_pc(a_spc), .stall_ifid(a_sifid), .stall_idex(a_sidex),
        .stall_exmem(a_sexmem), .bubble_idex(a_bidex), .bubble_exmem(a_bexmem),
        .flush_ifid(a_flush), .mdu_timeout_err(a_err), .stall_cycles(a_sc)
    );

    pipeline_stall_ctrl #(.LOAD_USE_BUBBLES(1), .MDU_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
        .memread_ex(memread_ex), .branch_taken_ex(branch_taken_ex),
        .mdu_req_ex(mdu_req_ex), .mdu_done(mdu_done), .mdu_start(b_start),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .stall_pc(b_spc), .stall_ifid(b_sifid), .stall_idex(b_sidex),
        .stall_exmem(b_sexmem), .bubble_idex(b_bidex), .bubble_exmem(b_bexmem),
        .flush_ifid(b_flush), .mdu_timeout_err(b_err), .stall_cycles(b_sc)
    );

    // A single EX slot cannot hold an MDU op and a taken branch together.
    always @(posedge clk) begin
        if (!rst && mdu_req_ex && branch_taken_ex) begin
            fails++;
            $display("FAIL illegal_ex: mdu_req_ex=1 with branch_taken_ex=1, required not both");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        use_rs1_id = 0; use_rs2_id = 0; memread_ex = 0; branch_taken_ex = 0;
        mdu_req_ex = 0; mdu_done = 0; dmem_req_mem = 0; dmem_ready = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (outs_a !== c_NONE) begin fails++; $display("FAIL reset_outs_a: got %b required %b", outs_a, c_NONE); end
        tests++;
        if (outs_b !== c_NONE) begin fails++; $display("FAIL reset_outs_b: got %b required %b", outs_b, c_NONE); end
        tests++;
        if (a_sc !== 32'd0 || a_err !== 1'b0) begin
            fails++; $display("FAIL reset_cnt_err: sc=%0d err=%b required 0/0", a_sc, a_err);
        end
        next_cycle();
    endtask

    task automatic test_async_reset_mid_mdu();
        do_reset();
        mdu_req_ex = 1;
        @(negedge clk);
        tests++;
        if (outs_a !== c_MDU_LAUNCH) begin fails++; $display("FAIL arst_launch: got %b required %b", outs_a, c_MDU_LAUNCH); end
        next_cycle();
        @(negedge clk);
        tests++;
        if (outs_a !== c_MDU_HOLD) begin fails++; $display("FAIL arst_hold: got %b required %b", outs_a, c_MDU_HOLD); end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (outs_a !== c_NONE || outs_b !== c_NONE) begin
            fails++; $display("FAIL arst_outs: got a=%b b=%b required %b", outs_a, outs_b, c_NONE);
        end
        tests++;
        if (a_sc !== 32'd0 || a_err !== 1'b0) begin
            fails++; $display("FAIL arst_cnt: sc=%0d err=%b required 0/0", a_sc, a_err);
        end
        next_cycle();
        mdu_req_ex = 0;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if (outs_a !== c_NONE) begin fails++; $display("FAIL arst_idle_%0d: got %b required %b", c, outs_a, c_NONE); end
            next_cycle();
        end
        tests++;
        if (a_sc !== 32'd0) begin fails++; $display("FAIL arst_sc: got %0d required 0", a_sc); end
    endtask

    task automatic test_load_use();
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                memread_ex = 1; rd_ex = 5'd5; rs2_id = 5'd5; use_rs2_id = 1;
                rs1_id = 5'd5; use_rs1_id = 0;
            end else begin
                idle_inputs();
            end
            exp_a = (c < 2) ? c_LDUSE : c_NONE;
            exp_b = (c < 1) ? c_LDUSE : c_NONE;
            @(negedge clk);
            tests++;
            if (outs_a !== exp_a) begin fails++; $display("FAIL ldu2_c%0d: got %b required %b", c, outs_a, exp_a); end
            tests++;
            if (outs_b !== exp_b) begin fails++; $display("FAIL ldu1_c%0d: got %b required %b", c, outs_b, exp_b); end
            next_cycle();
        end
        tests++;
        if (a_sc !== 32'd2) begin fails++; $display("FAIL ldu2_sc: got %0d required 2", a_sc); end
        tests++;
        if (b_sc !== 32'd1) begin fails++; $display("FAIL ldu1_sc: got %0d required 1", b_sc); end
        // rs1 matches but is not read: no hazard
        memread_ex = 1; rd_ex = 5'd9; rs1_id = 5'd9; use_rs1_id = 0; rs2_id = 5'd3; use_rs2_id = 1;
        @(negedge clk);
        tests++;
        if (outs_a !== c_NONE) begin fails++; $display("FAIL ldu_unused_rs: got %b required %b", outs_a, c_NONE); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_x0_branch();
        do_reset();
        memread_ex = 1; rd_ex = 5'd0; rs1_id = 5'd0; use_rs1_id = 1;
        @(negedge clk);
        tests++;
        if (outs_a !== c_NONE) begin fails++; $display("FAIL x0_nostall: got %b required %b", outs_a, c_NONE); end
        next_cycle();
        memread_ex = 1; rd_ex = 5'd7; rs1_id = 5'd7; use_rs1_id = 1; branch_taken_ex = 1;
        @(negedge clk);
        tests++;
        if (outs_a !== c_BRANCH) begin fails++; $display("FAIL branch_ldu: got %b required %b", outs_a, c_BRANCH); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        tests++;
        if (outs_a !== c_NONE) begin fails++; $display("FAIL branch_after: got %b required %b", outs_a, c_NONE); end
        next_cycle();
        tests++;
        if (a_sc !== 32'd0) begin fails++; $display("FAIL branch_sc: got %0d required 0", a_sc); end
    endtask

    task automatic test_mdu();
        int starts;
        logic [7:0] exp;
        starts = 0;
        do_reset();
        mdu_req_ex = 1;
        for (int c = 0; c < 8; c++) begin
            mdu_done = (c == 7);
            exp = (c == 0) ? c_MDU_LAUNCH : ((c == 7) ? c_NONE : c_MDU_HOLD);
            @(negedge clk);
            tests++;
            if (outs_a !== exp) begin fails++; $display("FAIL mdu_c%0d: got %b required %b", c, outs_a, exp); end
            if (a_start === 1'b1) starts++;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        tests++;
        if (outs_a !== c_NONE) begin fails++; $display("FAIL mdu_after: got %b required %b", outs_a, c_NONE); end
        tests++;
        if (starts != 1) begin fails++; $display("FAIL mdu_starts: got %0d required 1", starts); end
        tests++;
        if (a_sc !== 32'd7) begin fails++; $display("FAIL mdu_sc: got %0d required 7", a_sc); end
        tests++;
        if (a_err !== 1'b0) begin fails++; $display("FAIL mdu_err: got %b required 0", a_err); end
        next_cycle();
    endtask

    task automatic test_mdu_timeout();
        logic [7:0] exp;
        do_reset();
        mdu_req_ex = 1;
        for (int c = 0; c < 5; c++) begin
            exp = (c == 0) ? c_MDU_LAUNCH : ((c == 4) ? c_NONE : c_MDU_HOLD);
            @(negedge clk);
            tests++;
            if (outs_b !== exp) begin fails++; $display("FAIL to_c%0d: got %b required %b", c, outs_b, exp); end
            tests++;
            if (b_err !== 1'b0) begin fails++; $display("FAIL to_early_err_c%0d: got %b required 0", c, b_err); end
            next_cycle();
        end
        idle_inputs();
        tests++;
        if (b_err !== 1'b1) begin fails++; $display("FAIL to_err_set: got %b required 1", b_err); end
        tests++;
        if (b_sc !== 32'd4) begin fails++; $display("FAIL to_sc: got %0d required 4", b_sc); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests++;
        if (b_err !== 1'b1 || outs_b !== c_NONE) begin
            fails++; $display("FAIL to_sticky: err=%b outs=%b required 1/%b", b_err, outs_b, c_NONE);
        end
        do_reset();
        tests++;
        if (b_err !== 1'b0) begin fails++; $display("FAIL to_err_clr: got %b required 0", b_err); end
    endtask

    task automatic test_dmem_wait();
        logic [7:0] exp;
        do_reset();
        mdu_req_ex = 1; dmem_req_mem = 1; dmem_ready = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 4) dmem_ready = 1;
            if (c == 5) begin dmem_req_mem = 0; dmem_ready = 0; end
            if (c == 6) mdu_done = 1;
            exp = (c < 4) ? c_DMEM : ((c == 5) ? c_MDU_LAUNCH : c_NONE);
            @(negedge clk);
            tests++;
            if (outs_a !== exp) begin fails++; $display("FAIL dmem_c%0d: got %b required %b", c, outs_a, exp); end
            next_cycle();
        end
        idle_inputs();
        tests++;
        if (a_sc !== 32'd5) begin fails++; $display("FAIL dmem_sc: got %0d required 5", a_sc); end
    endtask

    initial begin
        test_reset();
        test_async_reset_mid_mdu();
        test_load_use();
        test_x0_branch();
        test_mdu();
        test_mdu_timeout();
        test_dmem_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
